// File: rtl/axi4_lite_reg_file.sv
// AXI4-Lite slave register file: REGS little-endian registers of 8*N bits with
// byte strobes, SLVERR decode and per-register write/read strobes.
module axi4_lite_reg_file #(
  parameter int unsigned A        = 12,
  parameter int unsigned N        = 4,
  parameter int unsigned REGS     = 16,
  parameter int unsigned USE_STRB = 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [A-1:0]          awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [8*N-1:0]        wdata,
  input  logic [N-1:0]          wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [A-1:0]          araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [8*N-1:0]        rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [REGS*8*N-1:0]   reg_q,
  output logic [REGS-1:0]       wr_pulse,
  output logic [REGS-1:0]       rd_pulse
);
  localparam int unsigned DW  = 8 * N;
  localparam int unsigned LSB = $clog2(N);
  localparam int unsigned IW  = $clog2(REGS);

  // Any address bit above the word-index field selects a non-existent register.
  function automatic logic out_of_range(input logic [A-1:0] addr);
    return |(addr >> (LSB + IW));
  endfunction

  logic [DW-1:0]   regs_q [REGS];
  logic            aw_held_q, w_held_q, aw_oor_q;
  logic [IW-1:0]   aw_idx_q;
  logic [DW-1:0]   wdata_q;
  logic [N-1:0]    wstrb_q;
  logic            bvalid_q, rvalid_q;
  logic [1:0]      bresp_q, rresp_q;
  logic [DW-1:0]   rdata_q, rdata_d, wr_word_d;
  logic [REGS-1:0] wr_pulse_q, wr_pulse_d, rd_pulse_q, rd_pulse_d;

  logic          aw_hs, w_hs, ar_hs, commit, ar_oor;
  logic [IW-1:0] ar_idx;

  assign awready = !areset && !aw_held_q && !bvalid_q;
  assign wready  = !areset && !w_held_q && !bvalid_q;
  assign arready = !areset && !rvalid_q;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign ar_hs  = arvalid && arready;
  assign commit = aw_held_q && w_held_q;
  assign ar_idx = araddr[LSB +: IW];
  assign ar_oor = out_of_range(araddr);

  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign rvalid   = rvalid_q;
  assign rresp    = rresp_q;
  assign rdata    = rdata_q;
  assign wr_pulse = wr_pulse_q;
  assign rd_pulse = rd_pulse_q;

  always_comb begin
    for (int unsigned i = 0; i < REGS; i++) reg_q[i*DW +: DW] = regs_q[i];
  end

  always_comb begin
    wr_word_d = regs_q[aw_idx_q];
    for (int unsigned k = 0; k < N; k++) begin
      if (USE_STRB == 0 || wstrb_q[k]) wr_word_d[k*8 +: 8] = wdata_q[k*8 +: 8];
    end
    wr_pulse_d = '0;
    if (commit && !aw_oor_q) wr_pulse_d[aw_idx_q] = 1'b1;
    rd_pulse_d = '0;
    if (ar_hs && !ar_oor) rd_pulse_d[ar_idx] = 1'b1;
    rdata_d = ar_oor ? '0 : regs_q[ar_idx];
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int unsigned i = 0; i < REGS; i++) regs_q[i] <= '0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_oor_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= '0;
      wr_pulse_q <= '0;
      rd_pulse_q <= '0;
    end else begin
      // Ready gating keeps a capture and a commit from ever hitting the same edge.
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= awaddr[LSB +: IW];
        aw_oor_q  <= out_of_range(awaddr);
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= wdata;
        wstrb_q  <= wstrb;
      end
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= aw_oor_q ? 2'b10 : 2'b00;
        if (!aw_oor_q) regs_q[aw_idx_q] <= wr_word_d;
      end else if (bvalid_q && bready) begin
        bvalid_q <= 1'b0;
      end
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
        rresp_q  <= ar_oor ? 2'b10 : 2'b00;
      end else if (rvalid_q && rready) begin
        rvalid_q <= 1'b0;
      end
      wr_pulse_q <= wr_pulse_d;
      rd_pulse_q <= rd_pulse_d;
    end
  end
endmodule
